// File: rtl/acc_breg_alu_if.sv
// Bus/control bundle between the acc_breg_alu slice and its surroundings.
// Latency: none, this is wiring only.
// Backpressure: none; loads and output enables are single-cycle strobes.
// Ports: bus_in/prog_in data, per-register we/load/oe strobes, HLT, SUB;
//        bus_out/bus_drive toward the bus, acc_q/breg_q/alu_q observation,
//        carry/zero flags only when ALU_FLAGS_EN is defined.
interface acc_breg_alu_if;
   logic       HLT;
   logic [7:0] bus_in;
   logic [7:0] prog_in;
   logic       acc_we;
   logic       acc_load;
   logic       acc_oe;
   logic       breg_we;
   logic       breg_load;
   logic       breg_oe;
   logic       alu_oe;
   logic       SUB;
   logic [7:0] bus_out;
   logic       bus_drive;
   logic [7:0] acc_q;
   logic [7:0] breg_q;
   logic [7:0] alu_q;
`ifdef ALU_FLAGS_EN
   logic       carry;
   logic       zero;
`endif

   // Controller / bench side.
   modport master (
      output HLT, bus_in, prog_in, acc_we, acc_load, acc_oe,
             breg_we, breg_load, breg_oe, alu_oe, SUB,
`ifdef ALU_FLAGS_EN
      input  carry, zero,
`endif
      input  bus_out, bus_drive, acc_q, breg_q, alu_q
   );

   // Datapath side.
   modport slave (
      input  HLT, bus_in, prog_in, acc_we, acc_load, acc_oe,
             breg_we, breg_load, breg_oe, alu_oe, SUB,
`ifdef ALU_FLAGS_EN
      output carry, zero,
`endif
      output bus_out, bus_drive, acc_q, breg_q, alu_q
   );
endinterface

// File: rtl/acc_breg_alu.sv
// Accumulator, B register and add/subtract ALU slice of the SAP-style computer.
// Latency: register loads take one edge; ALU and bus drive are combinational.
// Backpressure: none; HLT freezes all loads and drops bus drive.
// Ports: CLK, RESET (async, active-low), io (acc_breg_alu_if.slave).
// Optional: ALU_FLAGS_EN adds registered carry/zero flags.
module acc_breg_alu (
   input  logic           CLK,
   input  logic           RESET,
   acc_breg_alu_if.slave  io
);

   logic [7:0] acc;
   logic [7:0] breg;
   logic [7:0] b_op;
   logic [7:0] alu_res;

   // Bus write beats programmer write; HLT blocks both.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         acc <= 8'h00;
      end else if (!io.HLT) begin
         if (io.acc_we)        acc <= io.bus_in;
         else if (io.acc_load) acc <= io.prog_in;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         breg <= 8'h00;
      end else if (!io.HLT) begin
         if (io.breg_we)        breg <= io.bus_in;
         else if (io.breg_load) breg <= io.prog_in;
      end
   end

   // Subtract is A + ~B + 1 (two's complement).
   assign b_op = io.SUB ? ~breg : breg;

`ifdef ALU_FLAGS_EN
   logic [8:0] sum9;
   logic       carry_r;
   logic       zero_r;

   // Bit 8 is the carry out; for subtract it reads as "no borrow".
   assign sum9    = {1'b0, acc} + {1'b0, b_op} + {8'h00, io.SUB};
   assign alu_res = sum9[7:0];

   // Flags capture only on cycles where the ALU actually drives the bus.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         carry_r <= 1'b0;
         zero_r  <= 1'b0;
      end else if (io.alu_oe && !io.HLT) begin
         carry_r <= sum9[8];
         zero_r  <= (sum9[7:0] == 8'h00);
      end
   end

   assign io.carry = carry_r;
   assign io.zero  = zero_r;
`else
   assign alu_res = acc + b_op + {7'h00, io.SUB};
`endif

   // Fixed drive priority: ALU, then A, then B. Shows current register
   // contents, so a simultaneous OE+WE presents the old value this cycle.
   always_comb begin
      io.bus_out   = 8'h00;
      io.bus_drive = 1'b0;
      if (!io.HLT) begin
         if (io.alu_oe) begin
            io.bus_out   = alu_res;
            io.bus_drive = 1'b1;
         end else if (io.acc_oe) begin
            io.bus_out   = acc;
            io.bus_drive = 1'b1;
         end else if (io.breg_oe) begin
            io.bus_out   = breg;
            io.bus_drive = 1'b1;
         end
      end
   end

   assign io.acc_q  = acc;
   assign io.breg_q = breg;
   assign io.alu_q  = alu_res;

endmodule

// File: tb/tb_acc_breg_alu.sv
// Directed bench for acc_breg_alu: expected values go to a scoreboard queue
// as each step is driven and are popped when the output is sampled.
module tb_acc_breg_alu;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       loop_bus;
   logic [7:0] bus_val;

   acc_breg_alu_if ifc ();

   acc_breg_alu dut (
      .CLK   (CLK),
      .RESET (RESET),
      .io    (ifc)
   );

   // External bus: either bench-driven or looped back from the slice.
   assign ifc.bus_in = loop_bus ? ifc.bus_out : bus_val;

   always #5 CLK = ~CLK;

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic push(input logic [7:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $error("FAIL %s: observed %02h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) n_pass++;
         else $error("FAIL %s: observed %02h expected %02h", tag, obs, e);
      end
   endtask

   // Advance past the next rising edge; sample 1 time unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ifc.HLT = 0; ifc.acc_we = 0; ifc.acc_load = 0; ifc.acc_oe = 0;
      ifc.breg_we = 0; ifc.breg_load = 0; ifc.breg_oe = 0; ifc.alu_oe = 0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RESET = 0; loop_bus = 0; bus_val = 8'h00;
      ifc.prog_in = 8'h00; ifc.SUB = 0;
      idle();
      #2;
      // Reset state
      push(8'h00); check("rst_acc",   ifc.acc_q);
      push(8'h00); check("rst_breg",  ifc.breg_q);
      push(8'h00); check("rst_alu",   ifc.alu_q);
      push(8'h00); check("rst_drive", ifc.bus_drive);
      push(8'h00); check("rst_bus",   ifc.bus_out);
`ifdef ALU_FLAGS_EN
      push(8'h00); check("rst_carry", ifc.carry);
      push(8'h00); check("rst_zero",  ifc.zero);
`endif
      // Load A=5A, then assert reset mid-cycle with a pending bus load.
      RESET = 1; ifc.acc_load = 1; ifc.prog_in = 8'h5A;
      tick();
      push(8'h5A); check("pre_rst_acc", ifc.acc_q);
      #2;
      RESET = 0; ifc.acc_load = 0; ifc.acc_we = 1; bus_val = 8'h77;
      #1;
      push(8'h00); check("async_rst_acc", ifc.acc_q);
      push(8'h00); check("async_rst_drive", ifc.bus_drive);
      tick();
      push(8'h00); check("rst_load_discard", ifc.acc_q);

      // Deassert mid-cycle; the load requested now lands at the next edge.
      RESET = 1; ifc.acc_we = 0; ifc.acc_load = 1; ifc.prog_in = 8'h1C;
      tick();
      push(8'h1C); check("prog_acc", ifc.acc_q);
      ifc.acc_load = 0; ifc.breg_load = 1; ifc.prog_in = 8'h0E;
      tick();
      push(8'h0E); check("prog_breg", ifc.breg_q);
      ifc.breg_load = 0; ifc.SUB = 0; ifc.alu_oe = 1;
      #1;
      push(8'h2A); check("add_bus", ifc.bus_out);
      push(8'h01); check("add_drive", ifc.bus_drive);
      tick();
`ifdef ALU_FLAGS_EN
      push(8'h00); check("add_carry", ifc.carry);
      push(8'h00); check("add_zero",  ifc.zero);
`endif
      // A=05, B=07, subtract wraps.
      ifc.alu_oe = 0; ifc.acc_we = 1; bus_val = 8'h05;
      ifc.breg_load = 1; ifc.prog_in = 8'h07;
      tick();
      idle(); ifc.SUB = 1;
      #1;
      push(8'hFE); check("sub_wrap", ifc.alu_q);
      ifc.alu_oe = 1;
      tick();
`ifdef ALU_FLAGS_EN
      push(8'h00); check("sub_wrap_carry", ifc.carry);
`endif
      // A=07, B=07 subtract -> zero, no borrow.
      ifc.alu_oe = 0; ifc.acc_load = 1; ifc.prog_in = 8'h07;
      tick();
      idle();
      #1;
      push(8'h00); check("sub_zero", ifc.alu_q);
      ifc.alu_oe = 1;
      tick();
`ifdef ALU_FLAGS_EN
      push(8'h01); check("sub_zero_zf",  ifc.zero);
      push(8'h01); check("sub_zero_cf",  ifc.carry);
`endif
      // A=F0, B=20 add -> 10 with carry.
      ifc.alu_oe = 0; ifc.acc_load = 1; ifc.prog_in = 8'hF0;
      ifc.breg_we = 1; bus_val = 8'h20;
      tick();
      idle(); ifc.SUB = 0;
      #1;
      push(8'h10); check("add_wrap", ifc.alu_q);
      ifc.alu_oe = 1;
      tick();
`ifdef ALU_FLAGS_EN
      push(8'h01); check("add_wrap_cf", ifc.carry);
      push(8'h00); check("add_wrap_zf", ifc.zero);
`endif
      // Write priority: bus beats programmer on both registers.
      idle();
      ifc.acc_we = 1; ifc.acc_load = 1; bus_val = 8'h33; ifc.prog_in = 8'h44;
      tick();
      push(8'h33); check("prio_acc", ifc.acc_q);
      idle();
      ifc.breg_we = 1; ifc.breg_load = 1; bus_val = 8'h55; ifc.prog_in = 8'h66;
      tick();
      push(8'h55); check("prio_breg", ifc.breg_q);

      // Drive priority with A=33, B=55.
      idle(); ifc.alu_oe = 1; ifc.acc_oe = 1; ifc.breg_oe = 1;
      #1;
      push(8'h88); check("oe_alu", ifc.bus_out);
      ifc.alu_oe = 0;
      #1;
      push(8'h33); check("oe_acc", ifc.bus_out);
      ifc.acc_oe = 0;
      #1;
      push(8'h55); check("oe_breg", ifc.bus_out);

      // Simultaneous OE and WE on A: old value on bus, new value after edge.
      idle(); ifc.acc_oe = 1; ifc.acc_we = 1; bus_val = 8'h11;
      #1;
      push(8'h33); check("oe_we_old", ifc.bus_out);
      tick();
      push(8'h11); check("oe_we_new", ifc.acc_q);

      // Halt: no load, no drive, flags hold.
      ifc.HLT = 1; ifc.acc_we = 1; ifc.acc_oe = 1; ifc.alu_oe = 1; bus_val = 8'h99;
      #1;
      push(8'h00); check("hlt_drive", ifc.bus_drive);
      push(8'h00); check("hlt_bus",   ifc.bus_out);
      tick();
      push(8'h11); check("hlt_acc", ifc.acc_q);
`ifdef ALU_FLAGS_EN
      push(8'h01); check("hlt_carry_hold", ifc.carry);
`endif
      ifc.HLT = 0; ifc.acc_oe = 0; ifc.alu_oe = 0;
      tick();
      push(8'h99); check("hlt_resume", ifc.acc_q);

      // Accumulate loop: A=03, B=04, A <- A+B each edge via the bus.
      idle(); ifc.acc_we = 1; bus_val = 8'h03; ifc.breg_load = 1; ifc.prog_in = 8'h04;
      tick();
      idle(); ifc.SUB = 0; loop_bus = 1; ifc.alu_oe = 1; ifc.acc_we = 1;
      tick();
      push(8'h07); check("acc_loop1", ifc.acc_q);
      tick();
      push(8'h0B); check("acc_loop2", ifc.acc_q);
      tick();
      push(8'h0F); check("acc_loop3", ifc.acc_q);
      idle(); loop_bus = 0;
`ifdef ALU_FLAGS_EN
      push(8'h00); check("acc_loop_cf", ifc.carry);
`endif
      #1;
      push(8'h13); check("acc_loop_alu", ifc.alu_q);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
